// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core MEM stage and a variable-latency data SRAM.
// Stores retire into a FIFO and drain in the background; loads forward from it or go to memory.
module dmem_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AWIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CORE_CSN,
    input  logic                     CORE_WEN,
    input  logic [AWIDTH-1:0]        CORE_ADDR,
    input  logic [3:0]               CORE_BE,
    input  logic [31:0]              CORE_WDATA,
    output logic [31:0]              CORE_RDATA,
    output logic                     CORE_READY,
    output logic                     MEM_CSN,
    output logic                     MEM_WEN,
    output logic [AWIDTH-1:0]        MEM_ADDR,
    output logic [3:0]               MEM_BE,
    output logic [31:0]              MEM_WDATA,
    input  logic [31:0]              MEM_RDATA,
    input  logic                     MEM_READY,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned WAW = AWIDTH - 2;

    typedef struct packed {
        logic [WAW-1:0] waddr;
        logic [3:0]     be;
        logic [31:0]    data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;

    entry_t        fifo [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    state_t        state;
    logic          load_wait;

    logic           is_store;
    logic           is_load;
    logic           full;
    logic           push;
    logic           pop;
    logic           hit;
    logic [3:0]     hit_be;
    logic [31:0]    hit_data;
    logic [PW-1:0]  idx;
    logic           fwd;
    logic           partial;
    logic           load_go;
    logic           load_done;
    logic           drain_go;
    logic           idle_nxt;
    logic [31:0]    be_mask;
    logic [CW-1:0]  count_nxt;
    logic [WAW-1:0] core_waddr;
    entry_t         core_entry;
    entry_t         head_entry;
    logic           unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, CORE_ADDR[1:0]};

    // Youngest matching entry wins: scan oldest to youngest and keep the last hit.
    always_comb begin
        hit      = 1'b0;
        hit_be   = '0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < COUNT) && (fifo[idx].waddr == core_waddr)) begin
                hit      = 1'b1;
                hit_be   = fifo[idx].be;
                hit_data = fifo[idx].data;
            end
        end
    end

    // Request decode, forwarding and the combinational core response.
    always_comb begin
        core_waddr       = CORE_ADDR[AWIDTH-1:2];
        core_entry.waddr = core_waddr;
        core_entry.be    = CORE_BE;
        core_entry.data  = CORE_WDATA;

        is_store  = !CORE_CSN && !CORE_WEN;
        is_load   = !CORE_CSN && CORE_WEN;
        full      = (COUNT == CW'(DEPTH));
        pop       = (state == DRAIN) && MEM_READY;
        push      = !RST && is_store && (!full || pop);
        fwd       = is_load && hit && ((hit_be & CORE_BE) == CORE_BE);
        partial   = is_load && hit && !fwd;
        load_done = (state == LOAD) && MEM_READY;
        // A load that once saw a partial hit waits for a fully drained buffer.
        load_go   = !RST && (state == IDLE) && is_load && !hit &&
                    !(load_wait && (COUNT != '0));

        // With an empty buffer the incoming store is the head and drains straight away.
        head_entry = (COUNT == '0) ? core_entry : fifo[head];
        drain_go   = (state == IDLE) && !load_go && ((COUNT != '0) || push);
        idle_nxt   = (state == IDLE) ? !(load_go || drain_go) : (pop || load_done);
        count_nxt  = COUNT + CW'(push) - CW'(pop);

        be_mask = '0;
        for (int b = 0; b < 4; b++) begin
            be_mask[8*b +: 8] = {8{CORE_BE[b]}};
        end

        CORE_READY = push || (!RST && (fwd || load_done));
        CORE_RDATA = '0;
        if (!RST) begin
            if (load_done) begin
                CORE_RDATA = MEM_RDATA;
            end else if (fwd) begin
                CORE_RDATA = hit_data & be_mask;
            end
        end
    end

    // Entry storage; contents are qualified by COUNT so they need no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo[tail] <= core_entry;
        end
    end

    // Pointers, occupancy and the memory-side FSM with registered MEM outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            COUNT     <= '0;
            EMPTY     <= 1'b1;
            load_wait <= 1'b0;
            MEM_CSN   <= 1'b1;
            MEM_WEN   <= 1'b1;
            MEM_ADDR  <= '0;
            MEM_BE    <= '0;
            MEM_WDATA <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            COUNT     <= count_nxt;
            EMPTY     <= (count_nxt == '0) && idle_nxt;
            load_wait <= is_load && !load_done && (load_wait || partial);

            case (state)
                IDLE: begin
                    if (load_go) begin
                        state     <= LOAD;
                        MEM_CSN   <= 1'b0;
                        MEM_WEN   <= 1'b1;
                        MEM_ADDR  <= {core_waddr, 2'b00};
                        MEM_BE    <= CORE_BE;
                        MEM_WDATA <= '0;
                    end else if (drain_go) begin
                        state     <= DRAIN;
                        MEM_CSN   <= 1'b0;
                        MEM_WEN   <= 1'b0;
                        MEM_ADDR  <= {head_entry.waddr, 2'b00};
                        MEM_BE    <= head_entry.be;
                        MEM_WDATA <= head_entry.data;
                    end
                end
                DRAIN, LOAD: begin
                    if (MEM_READY) begin
                        state   <= IDLE;
                        MEM_CSN <= 1'b1;
                        MEM_WEN <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    MEM_CSN <= 1'b1;
                    MEM_WEN <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: a memory model checks every MEM request against an
// expected-transaction queue and a monitor checks every load completion against expected data.
module tb_dmem_store_buffer;
    logic        clk;
    logic        rst;
    logic        core_csn;
    logic        core_wen;
    logic [31:0] core_addr;
    logic [3:0]  core_be;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic        mem_csn;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        empty;
    logic [2:0]  count;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mtx_t;

    mtx_t        exp_mem [$];
    logic [31:0] exp_rd  [$];
    logic [31:0] mem     [int unsigned];

    int checks = 0;
    int errors = 0;
    int lat = 1;
    bit busy = 0;
    bit late_pulse = 0;

    dmem_store_buffer #(.DEPTH(4), .AWIDTH(32)) dut (
        .CLK(clk), .RST(rst),
        .CORE_CSN(core_csn), .CORE_WEN(core_wen), .CORE_ADDR(core_addr),
        .CORE_BE(core_be), .CORE_WDATA(core_wdata), .CORE_RDATA(core_rdata),
        .CORE_READY(core_ready),
        .MEM_CSN(mem_csn), .MEM_WEN(mem_wen), .MEM_ADDR(mem_addr), .MEM_BE(mem_be),
        .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .MEM_READY(mem_ready),
        .EMPTY(empty), .COUNT(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_w(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        mtx_t t;
        t.wen = 1'b0; t.addr = a; t.be = be; t.wdata = d;
        exp_mem.push_back(t);
    endtask

    task automatic exp_r(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        mtx_t t;
        t.wen = 1'b1; t.addr = a; t.be = be; t.wdata = '0;
        exp_mem.push_back(t);
        exp_rd.push_back(d);
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        int unsigned k = int'(a >> 2);
        return mem.exists(k) ? mem[k] : 32'h0;
    endfunction

    // Memory model: latency lat cycles from first request cycle to the MEM_READY pulse.
    initial begin
        mtx_t        e;
        logic        cur_wen;
        logic [31:0] cur_addr;
        logic [3:0]  cur_be;
        logic [31:0] cur_wdata;
        logic [31:0] w;
        int          age;
        mem_ready = 1'b0;
        mem_rdata = '0;
        age = 0;
        cur_wen = 1'b1; cur_addr = '0; cur_be = '0; cur_wdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = '0;
            if (rst || mem_csn !== 1'b0) begin
                busy = 0;
                if (late_pulse) begin
                    mem_ready  = 1'b1;
                    late_pulse = 0;
                end
            end else if (!busy) begin
                busy = 1; age = 0;
                cur_wen = mem_wen; cur_addr = mem_addr; cur_be = mem_be; cur_wdata = mem_wdata;
                if (exp_mem.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected: got wen=%b addr=%h expected no request", cur_wen, cur_addr);
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_wen", 32'(cur_wen), 32'(e.wen));
                    check("mem_addr", cur_addr, e.addr);
                    check("mem_be", 32'(cur_be), 32'(e.be));
                    if (!e.wen) check("mem_wdata", cur_wdata, e.wdata);
                end
            end else begin
                age++;
                if (age == lat) begin
                    mem_ready = 1'b1;
                    if (cur_wen) begin
                        mem_rdata = rd_word(cur_addr);
                    end else begin
                        w = rd_word(cur_addr);
                        for (int b = 0; b < 4; b++)
                            if (cur_be[b]) w[8*b +: 8] = cur_wdata[8*b +: 8];
                        mem[int'(cur_addr >> 2)] = w;
                    end
                end
            end
        end
    end

    // Load-response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (core_ready === 1'b1 && core_csn === 1'b0 && core_wen === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL load_unexpected: got rdata %h expected no load response", core_rdata);
                end else begin
                    check("load_rdata", core_rdata, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                         output int waits, output int cnt_acc, output bit rdy_acc);
        bit acc = 0;
        core_csn = 1'b0; core_wen = 1'b0; core_addr = a; core_be = be; core_wdata = d;
        waits = 0; cnt_acc = 0; rdy_acc = 0;
        forever begin
            @(negedge clk);
            if (core_ready === 1'b1) begin
                acc = 1; cnt_acc = int'(count); rdy_acc = mem_ready;
            end
            @(posedge clk); #1;
            if (acc) break;
            waits++;
            if (waits > 200) begin
                checks++; errors++;
                $display("FAIL store_timeout: got no CORE_READY expected accept at %h", a);
                break;
            end
        end
        core_csn = 1'b1; core_wen = 1'b1;
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] be, output int waits);
        bit acc = 0;
        core_csn = 1'b0; core_wen = 1'b1; core_addr = a; core_be = be; core_wdata = '0;
        waits = 0;
        forever begin
            @(negedge clk);
            if (core_ready === 1'b1) acc = 1;
            @(posedge clk); #1;
            if (acc) break;
            waits++;
            if (waits > 200) begin
                checks++; errors++;
                $display("FAIL load_timeout: got no CORE_READY expected completion at %h", a);
                break;
            end
        end
        core_csn = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(empty === 1'b1 && !busy)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL %s: got EMPTY=%b expected 1 within 200 cycles", name, empty);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int w, c;
        bit r;
        rst = 1'b1;
        core_csn = 1'b1; core_wen = 1'b1; core_addr = '0; core_be = '0; core_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_core_ready", 32'(core_ready), 0);
        check("rst_core_rdata", core_rdata, 0);
        check("rst_mem_csn", 32'(mem_csn), 1);
        check("rst_mem_wen", 32'(mem_wen), 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", 32'(mem_be), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Post and drain, latency 1.
        lat = 1;
        exp_w(32'h100, 4'hF, 32'hDEADBEEF);
        store(32'h100, 4'hF, 32'hDEADBEEF, w, c, r);
        check("t1_wait", w, 0);
        @(negedge clk);
        check("t1_count", 32'(count), 1);
        check("t1_mem_csn", 32'(mem_csn), 0);
        @(negedge clk);
        @(negedge clk);
        check("t1_empty", 32'(empty), 1);
        check("t1_count_end", 32'(count), 0);
        wait_idle("t1_idle");

        // Fill and backpressure, latency 3; drain order checked by the memory scoreboard.
        lat = 3;
        for (int i = 0; i < 5; i++) exp_w(32'h1000 + 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            store(32'h1000 + 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i), w, c, r);
            check("t2_accept_wait", w, 0);
        end
        store(32'h1010, 4'hF, 32'hA0000004, w, c, r);
        check("t2_fifth_count_at_accept", c, 4);
        check("t2_fifth_with_mem_ready", 32'(r), 1);
        @(negedge clk);
        check("t2_count_after", 32'(count), 4);
        wait_idle("t2_idle");

        // Forward hit: no memory read.
        lat = 1;
        exp_w(32'h200, 4'hF, 32'h11223344);
        exp_rd.push_back(32'h00003344);
        store(32'h200, 4'hF, 32'h11223344, w, c, r);
        load(32'h200, 4'b0011, w);
        check("t3_fwd_wait", w, 0);
        wait_idle("t3_idle");

        // Partial hit: stall until drained, then read the merged word.
        mem[32'h300 >> 2] = 32'h55667788;
        exp_w(32'h300, 4'b0001, 32'hFFFFFFAA);
        exp_r(32'h300, 4'hF, 32'h556677AA);
        store(32'h300, 4'b0001, 32'hFFFFFFAA, w, c, r);
        load(32'h300, 4'hF, w);
        check("t4_partial_wait", w, 4);
        wait_idle("t4_idle");

        // Load miss takes priority over the queued drains.
        lat = 2;
        mem[32'h500 >> 2] = 32'hCAFEF00D;
        exp_w(32'h400, 4'hF, 32'h00000400);
        exp_r(32'h500, 4'hF, 32'hCAFEF00D);
        exp_w(32'h404, 4'hF, 32'h00000404);
        exp_w(32'h408, 4'hF, 32'h00000408);
        store(32'h400, 4'hF, 32'h00000400, w, c, r);
        store(32'h404, 4'hF, 32'h00000404, w, c, r);
        store(32'h408, 4'hF, 32'h00000408, w, c, r);
        load(32'h500, 4'hF, w);
        check("t5_load_wait", w, 4);
        wait_idle("t5_idle");

        // Reset in the middle of a drain; a late MEM_READY must be ignored.
        lat = 10;
        exp_w(32'h600, 4'hF, 32'h00000600);
        store(32'h600, 4'hF, 32'h00000600, w, c, r);
        store(32'h604, 4'hF, 32'h00000604, w, c, r);
        rst = 1'b1;
        @(negedge clk);
        check("t6_count_before", 32'(count), 2);
        check("t6_mem_csn_before", 32'(mem_csn), 0);
        late_pulse = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_mem_csn", 32'(mem_csn), 1);
        check("t6_count", 32'(count), 0);
        check("t6_empty", 32'(empty), 1);
        @(negedge clk);
        check("t6_late_ready_count", 32'(count), 0);
        check("t6_late_ready_csn", 32'(mem_csn), 1);
        check("t6_late_ready_empty", 32'(empty), 1);

        check("exp_mem_left", 32'(exp_mem.size()), 0);
        check("exp_rd_left", 32'(exp_rd.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
Posted-write buffer between the core's MEM stage and the variable-latency data SRAM that signals completion through READY. Stores retire into a small FIFO and the core continues. Entries drain to memory in the background. Loads either forward from the buffer, or wait until the buffer is drained and then go to memory. The block sits on the D_MEM_* interface in place of a direct core-to-SRAM connection.

Parameters:
DEPTH, 4, number of store entries (power of two, >=2)
AWIDTH, 32, byte-address width on both sides

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
CORE_CSN  in  1  core request, active-low
CORE_WEN  in  1  0=store, 1=load
CORE_ADDR  in  AWIDTH  byte address; bits [1:0] ignored
CORE_BE  in  4  byte enables
CORE_WDATA  in  32  store data
CORE_RDATA  out  32  load data
CORE_READY  out  1  request complete this cycle
MEM_CSN  out  1  memory request, active-low
MEM_WEN  out  1  0=write, 1=read
MEM_ADDR  out  AWIDTH  word-aligned address
MEM_BE  out  4  byte enables
MEM_WDATA  out  32  write data
MEM_RDATA  in  32  read data, valid when MEM_READY=1
MEM_READY  in  1  one-cycle pulse, transaction done
EMPTY  out  1  buffer empty and memory idle (fence)
COUNT  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Core holds CSN/WEN/ADDR/BE/WDATA stable until it samples CORE_READY=1. CORE_READY and CORE_RDATA are combinational. All MEM_* outputs are registered.
- Reset (sync, RST=1 at posedge):
  - Outputs: CORE_READY=0, CORE_RDATA=0, MEM_CSN=1, MEM_WEN=1, MEM_ADDR/BE/WDATA=0, COUNT=0, EMPTY=1.
  - FSM goes to IDLE and all entries are invalidated.
  - A mid-flight memory transaction is abandoned. Any MEM_READY seen after reset in IDLE is ignored.
- Entry format: {word addr, BE, data}. FIFO pointers wrap modulo DEPTH.
- Store accept:
  - If COUNT<DEPTH, CORE_READY=1 in the same cycle and the entry is written at the posedge.
  - If full, CORE_READY=0 until a drain completes. The store is accepted in the cycle that MEM_READY frees an entry; simultaneous push and pop leaves COUNT unchanged.
- Load:
  - Match means any valid entry has the same word address.
  - Forward: if the youngest matching entry's BE is a superset of CORE_BE, CORE_READY=1 the same cycle. CORE_RDATA = that entry's data with non-enabled bytes zeroed. No memory access.
  - No match: the load takes priority over drains. It is issued once the FSM is IDLE.
  - Partial match: the core stalls until COUNT=0, then the load is issued.
- FSM states:
  - IDLE: MEM_CSN=1.
    - Pending load eligible -> LOAD; the MEM request is registered at the posedge.
    - Else COUNT>0 -> DRAIN with the head entry.
  - DRAIN: MEM_CSN=0, MEM_WEN=0, head entry on MEM_ADDR/BE/WDATA, held stable.
    - On MEM_READY: pop head, go to IDLE. The next request issues one cycle later, so there is one idle cycle between memory transactions.
  - LOAD: MEM_CSN=0, MEM_WEN=1, core ADDR/BE latched.
    - On MEM_READY: CORE_READY=1 and CORE_RDATA=MEM_RDATA in that cycle, then go to IDLE.
- Stores arriving during LOAD are not possible (the core is stalled). Stores arriving during DRAIN are accepted if not full.
- EMPTY = (COUNT==0) and state==IDLE.
- MEM_READY outside DRAIN/LOAD is ignored.

Test Plan:
- Post and drain: store 0x100 = 0xDEADBEEF, BE=1111, MEM latency 1. CORE_READY=1 in cycle 0 and COUNT=1. MEM write to 0x100 is seen in cycle 1. EMPTY=1 after MEM_READY.
- Fill and backpressure: 5 back-to-back stores with latency 3. The first 4 accept immediately. The 5th holds CORE_READY=0 until the first MEM_READY and is accepted in that same cycle with COUNT staying 4. Drain order is FIFO.
- Forward: store 0x200 = 0x11223344, then load 0x200 BE=0011. CORE_READY=1 the same cycle, CORE_RDATA=0x00003344, MEM_CSN stays 1 for the load.
- Partial hit: store BE=0001 to 0x300, then load BE=1111 at 0x300. The core stalls until COUNT=0, then a MEM read at 0x300 returns the merged memory word.
- Load priority: 3 stores queued to 0x400/404/408, then load 0x500 (miss) while the first drain is in flight. The read to 0x500 issues before the 0x404 write.
- Reset mid-DRAIN: assert RST with COUNT=2 and MEM_CSN=0. Next cycle MEM_CSN=1, COUNT=0, EMPTY=1, and a late MEM_READY is ignored.
